// File: rtl/axi_slave_regfile_if.sv
// AXI3-style bus bundle between the nysa AXI master and the slave register bank.
// Signal names keep the master's i_/o_ prefixes as seen from the slave side.
interface axi_slave_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]            i_awid;
  logic [ADDR_WIDTH-1:0] i_awaddr;
  logic [3:0]            i_awlen;
  logic [2:0]            i_awsize;
  logic [1:0]            i_awburst;
  logic [1:0]            i_awlock;
  logic [3:0]            i_awcache;
  logic [2:0]            i_awprot;
  logic                  i_awvalid;
  logic                  o_awready;

  logic [3:0]            i_wid;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [DATA_WIDTH/8:0] i_wstrobe;
  logic                  i_wlast;
  logic                  i_wvalid;
  logic                  o_wready;

  logic [3:0]            o_bid;
  logic [1:0]            o_bresp;
  logic                  o_bvalid;
  logic                  i_bready;

  logic [3:0]            i_arid;
  logic [ADDR_WIDTH-1:0] i_araddr;
  logic [3:0]            i_arlen;
  logic [2:0]            i_arsize;
  logic [1:0]            i_arburst;
  logic [1:0]            i_arlock;
  logic [3:0]            i_arcache;
  logic [2:0]            i_arprot;
  logic                  i_arvalid;
  logic                  o_arready;

  logic [3:0]            o_rid;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic [1:0]            o_rresp;
  logic                  o_rlast;
  logic                  o_rvalid;
  logic                  i_rready;

  modport slave (
    input  i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awlock, i_awcache, i_awprot, i_awvalid,
    output o_awready,
    input  i_wid, i_wdata, i_wstrobe, i_wlast, i_wvalid,
    output o_wready,
    output o_bid, o_bresp, o_bvalid,
    input  i_bready,
    input  i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arlock, i_arcache, i_arprot, i_arvalid,
    output o_arready,
    output o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
    input  i_rready
  );

  modport master (
    output i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awlock, i_awcache, i_awprot, i_awvalid,
    input  o_awready,
    output i_wid, i_wdata, i_wstrobe, i_wlast, i_wvalid,
    input  o_wready,
    input  o_bid, o_bresp, o_bvalid,
    output i_bready,
    output i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arlock, i_arcache, i_arprot, i_arvalid,
    input  o_arready,
    input  o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
    output i_rready
  );
endinterface

// File: rtl/axi_slave_regfile.sv
// AXI3-style slave register bank of 2**ADDR_DEPTH words with FIXED/INCR bursts of 1-16 beats.
// Define AXI_SLAVE_WSTRB_EN to honour per-byte write strobes; otherwise accepted beats write whole words.
module axi_slave_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ADDR_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic               clk,
  input logic               rst,
  axi_slave_regfile_if.slave bus
);
  localparam int         WORDS  = 2 ** ADDR_DEPTH;
  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef logic [ADDR_DEPTH-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [2:0] size, input logic [1:0] burst);
    if (addr[ADDR_WIDTH-1:ADDR_DEPTH+2] != BASE_ADDR[ADDR_WIDTH-1:ADDR_DEPTH+2]) return DECERR;
    if (size != 3'd2 || burst[1]) return SLVERR;
    return OKAY;
  endfunction

  // FIXED bursts hold the index; INCR wraps modulo the word count.
  function automatic idx_t step_idx(input idx_t idx, input logic fixed);
    return fixed ? idx : idx_t'(idx + 1'b1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] mem_d [WORDS];

  w_state_t   w_state_q, w_state_d;
  logic [3:0] aw_id_q, aw_id_d, aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  idx_t       aw_idx_q, aw_idx_d;
  logic       aw_fixed_q, aw_fixed_d, lerr_q, lerr_d;
  logic [1:0] aw_resp_q, aw_resp_d;

  r_state_t              r_state_q, r_state_d;
  logic [3:0]            ar_id_q, ar_id_d, ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  idx_t                  ar_idx_q, ar_idx_d, ar_idx_next;
  logic                  ar_fixed_q, ar_fixed_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic aw_ready, ar_ready, w_last;

  assign aw_ready = (w_state_q == W_IDLE) && !rst;
  assign ar_ready = (r_state_q == R_IDLE) && !rst;
  assign w_last   = (w_cnt_q == aw_len_q);

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_idx_d   = aw_idx_q;
    aw_fixed_d = aw_fixed_q;
    aw_resp_d  = aw_resp_q;
    lerr_d     = lerr_q;
    w_cnt_d    = w_cnt_q;
    mem_d      = mem_q;
    case (w_state_q)
      W_IDLE: if (bus.i_awvalid && aw_ready) begin
        aw_id_d    = bus.i_awid;
        aw_len_d   = bus.i_awlen;
        aw_idx_d   = bus.i_awaddr[ADDR_DEPTH+1:2];
        aw_fixed_d = (bus.i_awburst == 2'd0);
        aw_resp_d  = decode_resp(bus.i_awaddr, bus.i_awsize, bus.i_awburst);
        lerr_d     = 1'b0;
        w_cnt_d    = '0;
        w_state_d  = W_DATA;
      end
      W_DATA: if (bus.i_wvalid) begin
        // The write gate uses the decode result only, so a wlast mismatch never blocks data.
        if (aw_resp_q == OKAY) begin
`ifdef AXI_SLAVE_WSTRB_EN
          for (int k = 0; k < DATA_WIDTH / 8; k++)
            if (bus.i_wstrobe[k]) mem_d[aw_idx_q][8*k +: 8] = bus.i_wdata[8*k +: 8];
`else
          mem_d[aw_idx_q] = bus.i_wdata;
`endif
        end
        if (bus.i_wlast != w_last) lerr_d = 1'b1;
        w_cnt_d  = w_cnt_q + 4'd1;
        aw_idx_d = step_idx(aw_idx_q, aw_fixed_q);
        if (w_last) w_state_d = W_RESP;
      end
      W_RESP:  if (bus.i_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    ar_id_d     = ar_id_q;
    ar_len_d    = ar_len_q;
    ar_idx_d    = ar_idx_q;
    ar_fixed_d  = ar_fixed_q;
    r_resp_d    = r_resp_q;
    r_cnt_d     = r_cnt_q;
    rdata_d     = rdata_q;
    ar_idx_next = step_idx(ar_idx_q, ar_fixed_q);
    case (r_state_q)
      R_IDLE: if (bus.i_arvalid && ar_ready) begin
        ar_id_d    = bus.i_arid;
        ar_len_d   = bus.i_arlen;
        ar_idx_d   = bus.i_araddr[ADDR_DEPTH+1:2];
        ar_fixed_d = (bus.i_arburst == 2'd0);
        r_resp_d   = decode_resp(bus.i_araddr, bus.i_arsize, bus.i_arburst);
        r_cnt_d    = '0;
        rdata_d    = (r_resp_d == OKAY) ? mem_q[ar_idx_d] : '0;
        r_state_d  = R_DATA;
      end
      R_DATA: if (bus.i_rready) begin
        if (r_cnt_q == ar_len_q) begin
          r_state_d = R_IDLE;
        end else begin
          // Prefetch the next beat on the same edge so rready held high streams 1 beat/clk.
          r_cnt_d  = r_cnt_q + 4'd1;
          ar_idx_d = ar_idx_next;
          rdata_d  = (r_resp_q == OKAY) ? mem_q[ar_idx_next] : '0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_idx_q   <= '0;
      aw_fixed_q <= 1'b0;
      aw_resp_q  <= OKAY;
      lerr_q     <= 1'b0;
      w_cnt_q    <= '0;
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_idx_q   <= '0;
      ar_fixed_q <= 1'b0;
      r_resp_q   <= OKAY;
      r_cnt_q    <= '0;
      rdata_q    <= '0;
      // NOTE: the word array is reset too, since software relies on config registers reading 0.
      mem_q      <= '{default: '0};
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_idx_q   <= aw_idx_d;
      aw_fixed_q <= aw_fixed_d;
      aw_resp_q  <= aw_resp_d;
      lerr_q     <= lerr_d;
      w_cnt_q    <= w_cnt_d;
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_len_q   <= ar_len_d;
      ar_idx_q   <= ar_idx_d;
      ar_fixed_q <= ar_fixed_d;
      r_resp_q   <= r_resp_d;
      r_cnt_q    <= r_cnt_d;
      rdata_q    <= rdata_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.o_awready = aw_ready;
  assign bus.o_wready  = (w_state_q == W_DATA);
  assign bus.o_bvalid  = (w_state_q == W_RESP);
  assign bus.o_bid     = aw_id_q;
  assign bus.o_bresp   = (aw_resp_q == OKAY && lerr_q) ? SLVERR : aw_resp_q;

  assign bus.o_arready = ar_ready;
  assign bus.o_rvalid  = (r_state_q == R_DATA);
  assign bus.o_rid     = ar_id_q;
  assign bus.o_rdata   = rdata_q;
  assign bus.o_rresp   = r_resp_q;
  assign bus.o_rlast   = (r_state_q == R_DATA) && (r_cnt_q == ar_len_q);

  logic unused_inputs;
`ifdef AXI_SLAVE_WSTRB_EN
  assign unused_inputs = ^{bus.i_wstrobe[DATA_WIDTH/8], bus.i_wid, bus.i_awlock, bus.i_awcache,
                           bus.i_awprot, bus.i_arlock, bus.i_arcache, bus.i_arprot,
                           bus.i_awaddr[1:0], bus.i_araddr[1:0]};
`else
  assign unused_inputs = ^{bus.i_wstrobe, bus.i_wid, bus.i_awlock, bus.i_awcache,
                           bus.i_awprot, bus.i_arlock, bus.i_arcache, bus.i_arprot,
                           bus.i_awaddr[1:0], bus.i_araddr[1:0]};
`endif
endmodule
